// File: rtl/fp_issue_if.sv
// Issue-stage bundle: decode handshake, operand/execute handshake and FP writeback port.
interface fp_issue_if;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_wen;
  logic [2:0]  id_fpuctrl;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [2:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_wen, id_fpuctrl,
    input  id_ready,
    input  ex_valid, ex_a, ex_b, ex_ctrl, ex_rd, ex_wen,
    output ex_ready,
    output wb_en, wb_rd, wb_data
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_wen, id_fpuctrl,
    output id_ready,
    output ex_valid, ex_a, ex_b, ex_ctrl, ex_rd, ex_wen,
    input  ex_ready,
    input  wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/fp_issue_stage.sv
// FP issue stage: register file with writeback bypass, scoreboard hazard check,
// single-entry operand register toward the FP adder, and a saturating stall counter.
module fp_issue_stage #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  fp_issue_if.slave              io,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            rf_q [32];
  logic [31:0]            rf_d [32];
  logic [31:0]            pend_q, pend_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]            ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [2:0]             ex_ctrl_q, ex_ctrl_d;
  logic [4:0]             ex_rd_q, ex_rd_d;
  logic                   ex_wen_q, ex_wen_d;

  logic byp_rs1, byp_rs2, byp_rd;
  logic hazard, ready, accept;

  // A register being written back this cycle is no longer a hazard for the reader.
  always_comb begin
    byp_rs1 = io.wb_en && (io.wb_rd == io.id_rs1);
    byp_rs2 = io.wb_en && (io.wb_rd == io.id_rs2);
    byp_rd  = io.wb_en && (io.wb_rd == io.id_rd);
    hazard  = (pend_q[io.id_rs1] && !byp_rs1) ||
              (pend_q[io.id_rs2] && !byp_rs2) ||
              (io.id_wen && pend_q[io.id_rd] && !byp_rd);
    ready   = !reset && !hazard && ((state_q == EMPTY) || io.ex_ready);
    accept  = io.id_valid && ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (io.ex_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rf_d        = rf_q;
    pend_d      = pend_q;
    stall_cnt_d = stall_cnt_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    ex_wen_d    = ex_wen_q;

    if (io.wb_en) begin
      rf_d[io.wb_rd]   = io.wb_data;
      pend_d[io.wb_rd] = 1'b0;
    end
    // Set after clear so a same-cycle set/clear on one register leaves it pending.
    if (accept && io.id_wen) pend_d[io.id_rd] = 1'b1;

    if (io.id_valid && hazard && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);

    if (accept) begin
      ex_a_d    = byp_rs1 ? io.wb_data : rf_q[io.id_rs1];
      ex_b_d    = byp_rs2 ? io.wb_data : rf_q[io.id_rs2];
      ex_ctrl_d = io.id_fpuctrl;
      ex_rd_d   = io.id_rd;
      ex_wen_d  = io.id_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      pend_q      <= '0;
      stall_cnt_q <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      ex_wen_q    <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      ex_wen_q    <= ex_wen_d;
      rf_q        <= rf_d;
    end
  end

  assign io.id_ready = ready;
  assign io.ex_valid = (state_q == FULL);
  assign io.ex_a     = ex_a_q;
  assign io.ex_b     = ex_b_q;
  assign io.ex_ctrl  = ex_ctrl_q;
  assign io.ex_rd    = ex_rd_q;
  assign io.ex_wen   = ex_wen_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fp_issue_stage.sv
// Bench for fp_issue_stage: directed vector table, hand-written saturation sequence,
// and random traffic checked every cycle against a behavioural model.
module tb_fp_issue_stage;
  localparam int unsigned W    = 4;
  localparam int unsigned CMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] stall_cnt;

  fp_issue_if bus();

  fp_issue_stage #(.STALL_CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_full;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_rd;
  bit          m_wen;
  int unsigned m_cnt;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [4:0]  rs1, rs2, rd;
    bit          wen;
    logic [2:0]  ctrl;
    bit          exr, wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    bit          e_rdy;
    bit          e_exv;
    logic [31:0] e_exa;
    int unsigned e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input bit rst, input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input bit wen, input logic [2:0] ctrl, input bit exr,
                     input bit wbe, input logic [4:0] wbrd, input logic [31:0] wbd);
    reset          = rst;
    bus.id_valid   = iv;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rd      = rd;
    bus.id_wen     = wen;
    bus.id_fpuctrl = ctrl;
    bus.ex_ready   = exr;
    bus.wb_en      = wbe;
    bus.wb_rd      = wbrd;
    bus.wb_data    = wbd;
  endtask

  // A register blocks the decoder if it is awaiting a result that is not arriving now.
  function automatic bit busy(input logic [4:0] r);
    return m_pend[r] && !(bus.wb_en && bus.wb_rd == r);
  endfunction

  function automatic bit m_hazard();
    return busy(bus.id_rs1) || busy(bus.id_rs2) || (bus.id_wen && busy(bus.id_rd));
  endfunction

  function automatic bit m_ready();
    return !reset && !m_hazard() && (!m_full || bus.ex_ready);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    return (bus.wb_en && bus.wb_rd == r) ? bus.wb_data : m_rf[r];
  endfunction

  // Compare all outputs against the model; called mid-cycle, away from the edge.
  task automatic observe();
    @(negedge clk);
    chk("id_ready",  {31'd0, bus.id_ready}, {31'd0, m_ready()});
    chk("ex_valid",  {31'd0, bus.ex_valid}, {31'd0, m_full});
    chk("ex_a",      bus.ex_a, m_a);
    chk("ex_b",      bus.ex_b, m_b);
    chk("ex_ctrl",   {29'd0, bus.ex_ctrl}, {29'd0, m_ctrl});
    chk("ex_rd",     {27'd0, bus.ex_rd}, {27'd0, m_rd});
    chk("ex_wen",    {31'd0, bus.ex_wen}, {31'd0, m_wen});
    chk("stall_cnt", {{(32-W){1'b0}}, stall_cnt}, m_cnt);
  endtask

  task automatic advance();
    bit acc;
    if (reset) begin
      m_full = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_rd = '0; m_wen = 0; m_cnt = 0;
      for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_pend[i] = 0; end
    end else begin
      acc = bus.id_valid && m_ready();
      if (bus.id_valid && m_hazard() && m_cnt < CMAX) m_cnt++;
      if (acc) begin
        m_a = operand(bus.id_rs1); m_b = operand(bus.id_rs2);
        m_ctrl = bus.id_fpuctrl; m_rd = bus.id_rd; m_wen = bus.id_wen;
        m_full = 1;
      end else if (bus.ex_ready) m_full = 0;
      if (bus.wb_en) begin m_rf[bus.wb_rd] = bus.wb_data; m_pend[bus.wb_rd] = 0; end
      if (acc && bus.id_wen) m_pend[bus.id_rd] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit rst, input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input bit wen, input logic [2:0] ctrl, input bit exr,
                     input bit wbe, input logic [4:0] wbrd, input logic [31:0] wbd,
                     input bit e_rdy, input bit e_exv, input logic [31:0] e_exa, input int unsigned e_cnt);
    vec_t v;
    v = '{rst, iv, rs1, rs2, rd, wen, ctrl, exr, wbe, wbrd, wbd, e_rdy, e_exv, e_exa, e_cnt};
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_pend[i] = 0; end
    m_full = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_rd = '0; m_wen = 0; m_cnt = 0;

    //   rst iv rs1 rs2 rd wen ctl exr wbe wbrd wbd            rdy exv exa            cnt
    add(0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 1, 32'h3F800000,       1, 0, 32'h00000000, 0);
    add(0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 2, 32'h40000000,       1, 0, 32'h00000000, 0);
    add(0, 1, 1, 2, 0, 0, 3'd0, 1, 0, 0, 32'h0,              1, 1, 32'h3F800000, 0);
    add(0, 1, 3, 0, 0, 0, 3'd0, 1, 1, 3, 32'h7F800000,       1, 1, 32'h7F800000, 0);
    add(0, 1, 0, 0, 5, 1, 3'd1, 1, 0, 0, 32'h0,              1, 1, 32'h00000000, 0);
    for (int k = 1; k <= 4; k++)
      add(0, 1, 5, 0, 0, 0, 3'd0, 1, 0, 0, 32'h0,            0, 0, 32'h00000000, k);
    add(0, 1, 5, 0, 0, 0, 3'd2, 1, 1, 5, 32'h12345678,       1, 1, 32'h12345678, 4);
    add(0, 1, 1, 2, 0, 0, 3'd0, 1, 0, 0, 32'h0,              1, 1, 32'h3F800000, 4);
    for (int k = 0; k < 3; k++)
      add(0, 1, 2, 1, 0, 0, 3'd3, 0, 0, 0, 32'h0,            0, 1, 32'h3F800000, 4);
    add(0, 1, 2, 1, 0, 0, 3'd3, 1, 0, 0, 32'h0,              1, 1, 32'h40000000, 4);
    add(0, 1, 0, 0, 7, 1, 3'd0, 1, 0, 0, 32'h0,              1, 1, 32'h00000000, 4);
    add(0, 1, 1, 0, 7, 1, 3'd0, 1, 1, 7, 32'hAAAA0000,       1, 1, 32'h3F800000, 4);
    add(0, 1, 7, 0, 0, 0, 3'd0, 1, 0, 0, 32'h0,              0, 0, 32'h3F800000, 5);
    add(0, 1, 7, 0, 0, 0, 3'd0, 1, 1, 7, 32'hBBBB0000,       1, 1, 32'hBBBB0000, 5);
    add(0, 1, 0, 0, 4, 1, 3'd0, 1, 0, 0, 32'h0,              1, 1, 32'h00000000, 5);
    for (int k = 6; k <= 9; k++)
      add(0, 1, 4, 0, 0, 0, 3'd0, 0, 0, 0, 32'h0,            0, 1, 32'h00000000, k);
    add(1, 1, 4, 0, 0, 0, 3'd0, 0, 1, 4, 32'hDEADBEEF,       0, 0, 32'h00000000, 0);
    add(0, 1, 4, 0, 0, 0, 3'd0, 1, 0, 0, 32'h0,              1, 1, 32'h00000000, 0);
    add(0, 1, 1, 7, 0, 0, 3'd0, 1, 0, 0, 32'h0,              1, 1, 32'h00000000, 0);

    // Reset state
    drv(1, 0, 0, 0, 0, 0, 3'd0, 1, 1, 9, 32'hFFFFFFFF);
    observe();
    chk("rst_id_ready", {31'd0, bus.id_ready}, 32'd0);
    advance();
    observe();
    advance();
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_stall",    {{(32-W){1'b0}}, stall_cnt}, 32'd0);

    foreach (tbl[i]) begin
      drv(tbl[i].rst, tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wen, tbl[i].ctrl,
          tbl[i].exr, tbl[i].wbe, tbl[i].wbrd, tbl[i].wbd);
      observe();
      chk($sformatf("vec%0d_ready", i), {31'd0, bus.id_ready}, {31'd0, tbl[i].e_rdy});
      advance();
      chk($sformatf("vec%0d_exv", i), {31'd0, bus.ex_valid}, {31'd0, tbl[i].e_exv});
      chk($sformatf("vec%0d_exa", i), bus.ex_a, tbl[i].e_exa);
      chk($sformatf("vec%0d_cnt", i), {{(32-W){1'b0}}, stall_cnt}, tbl[i].e_cnt);
    end

    // Saturation of the stall counter
    drv(0, 1, 0, 0, 9, 1, 3'd0, 1, 0, 0, 32'h0);
    observe();
    advance();
    for (int k = 1; k <= 20; k++) begin
      drv(0, 1, 9, 9, 0, 0, 3'd0, 1, 0, 0, 32'h0);
      observe();
      advance();
      chk($sformatf("sat%0d", k), {{(32-W){1'b0}}, stall_cnt}, (k > CMAX) ? CMAX : k);
    end
    drv(0, 0, 0, 0, 0, 0, 3'd0, 1, 1, 9, 32'h01020304);
    observe();
    advance();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
      observe();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_issue_stage.md
FP_ISSUE_STAGE -- requirements
Module: fp_issue_stage

Interface
REQ-001 Parameter STALL_CNT_W, default 16: width of the hazard-stall counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 id_valid  in  1  decode presents an FP instruction.
REQ-005 id_ready  out  1  stage accepts the instruction this cycle.
REQ-006 id_rs1, id_rs2  in  5 each  FP source register indices.
REQ-007 id_rd  in  5  FP destination register index.
REQ-008 id_wen  in  1  instruction writes id_rd.
REQ-009 id_fpuctrl  in  3  FPU opcode (3'b000 = ADD), passed through unchanged.
REQ-010 ex_valid  out  1  operand register holds a valid instruction for the FP adder.
REQ-011 ex_ready  in  1  FP execute stage consumes the held instruction.
REQ-012 ex_a, ex_b  out  32 each  IEEE-754 single operands for adder inputs a and b.
REQ-013 ex_ctrl  out  3  registered id_fpuctrl, drives FPUControl.
REQ-014 ex_rd  out  5; ex_wen  out  1  registered destination index and write flag.
REQ-015 wb_en  in  1; wb_rd  in  5; wb_data  in  32  FP result writeback port.
REQ-016 stall_cnt  out  STALL_CNT_W  count of hazard-stall cycles.

Function
REQ-017 Register file: 32 x 32-bit; f0 is a normal writable register, not hardwired to zero.
REQ-018 Writeback: when wb_en=1, regfile[wb_rd] <= wb_data at the clock edge.
REQ-019 Read bypass: when wb_en=1 and wb_rd equals rs1 (rs2), the captured operand is wb_data instead of the stale array value.
REQ-020 Scoreboard: one pending bit per register; set for id_rd when an instruction with id_wen=1 is accepted; cleared for wb_rd when wb_en=1.
REQ-021 Set and clear of the same register in the same cycle: set wins, so the bit stays 1.
REQ-022 Hazard is asserted when any of the following register conditions holds:
  - pending[rs1] and not (wb_en and wb_rd==rs1);
  - pending[rs2] and not (wb_en and wb_rd==rs2);
  - id_wen and pending[rd] and not (wb_en and wb_rd==rd) (WAW).
REQ-023 id_ready = !reset and !hazard and (!ex_valid or ex_ready); this is a combinational function of the current inputs and state.
REQ-024 Accept means id_valid and id_ready. On accept, ex_a, ex_b, ex_ctrl, ex_rd and ex_wen load at the same edge, and ex_valid becomes 1: latency is one cycle.
REQ-025 Output FSM has two states:
  - EMPTY (ex_valid=0) goes to FULL on accept;
  - FULL with ex_ready=1 and accept stays FULL and reloads (back-to-back, no bubble);
  - FULL with ex_ready=1 and no accept goes to EMPTY;
  - FULL with ex_ready=0 holds all ex_* outputs stable.
REQ-026 ex_* outputs change only on accept; ex_a, ex_b and ex_ctrl are don't-care while ex_valid=0, but they retain their last values.
REQ-027 stall_cnt increments by 1 on each cycle with id_valid=1 and hazard=1, and saturates at all-ones without wrapping.
REQ-028 A cycle with id_valid=1 blocked only by backpressure (FULL and ex_ready=0) is not counted.
REQ-029 An instruction with id_wen=0 never sets a pending bit and is never subject to the WAW check.

Reset
REQ-030 Reset applies at the clock edge while reset=1, and its effects are:
  - ex_valid=0;
  - all pending bits 0;
  - stall_cnt=0;
  - all 32 registers 0;
  - ex_a=ex_b=0, ex_ctrl=3'b000, ex_rd=0, ex_wen=0.
REQ-031 id_ready is 0 while reset=1, and a wb_en asserted during reset has no effect.
REQ-032 Reset asserted mid-operation discards the held instruction and all scoreboard state; id_ready may return to 1 in the first cycle after reset deasserts.

Verification
REQ-033 Write-then-read:
  - stimulus: wb f1=32'h3F800000 and f2=32'h40000000; then issue rs1=1, rs2=2, ctrl=000 with ex_ready=1;
  - required response: next cycle ex_valid=1, ex_a=3F800000, ex_b=40000000, ex_ctrl=000.
REQ-034 Bypass:
  - stimulus: in the same cycle, wb_en=1, wb_rd=3, wb_data=32'h7F800000, and issue rs1=3;
  - required response: ex_a=7F800000 one cycle later.
REQ-035 RAW stall:
  - stimulus: issue rd=5 with wen=1, then issue rs1=5 for 4 cycles without writeback, then wb rd=5;
  - required response: id_ready=0 for 4 cycles; stall_cnt=4; the dependent instruction is accepted in the wb cycle and carries wb_data.
REQ-036 Backpressure:
  - stimulus: hold ex_ready=0 for 3 cycles while ex_valid=1 and id_valid=1;
  - required response: ex_* stable, id_ready=0, stall_cnt unchanged; on ex_ready=1 the next instruction loads with no bubble.
REQ-037 Same-cycle set/clear:
  - stimulus: wb rd=7 while issuing wen=1, rd=7 (f7 previously pending);
  - required response: the issue is accepted and pending[7] stays 1, so a following read of f7 stalls until the next wb rd=7.
REQ-038 Reset mid-operation:
  - stimulus: assert reset for 1 cycle with ex_valid=1, pending[4]=1, stall_cnt=9;
  - required response: ex_valid=0, stall_cnt=0, and a read of f4 is accepted without stall, returning 0.
